// File: rtl/instr_loader.sv
// Boot-image loader: parses a 4-byte little-endian length header, then streams
// payload bytes into instruction memory while holding the core in reset.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
    parameter int unsigned MEM_BYTES     = 4096,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     s_valid_i,
    input  logic [DATA_WIDTH-1:0]    s_data_i,
    output logic                     s_ready_o,
    output logic                     we_o,
    output logic [ADDRESS_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0]    wdata_o,
    output logic                     cpu_rst_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [7:0]               checksum_o
);
    localparam int unsigned LEN_W     = 32;
    localparam int unsigned HDR_BYTES = 4;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_EVAL = 3'd1,
        S_LOAD = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [1:0]               r_hdr_cnt;
    logic [LEN_W-1:0]         r_len;
    logic [ADDRESS_WIDTH-1:0] r_cnt;
    logic                     r_ready;
    logic                     r_we;
    logic                     r_cpu_rst;
    logic                     r_done;
    logic                     r_err;
    logic [ADDRESS_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [7:0]               r_sum;

    logic w_fire;
    logic w_last;
    logic w_rearm;
    logic w_ready_d;
    logic w_cpu_rst_d;
    logic w_done_d;
    logic w_err_d;

    assign w_fire  = s_valid_i && r_ready;
    assign w_last  = (LEN_W'(r_cnt) == (r_len - LEN_W'(1)));
    assign w_rearm = start_i && ((r_state == S_DONE) || (r_state == S_ERR));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // S_EVAL is the single cycle in which the assembled length is judged
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_fire && (r_hdr_cnt == 2'(HDR_BYTES - 1))) begin
                    w_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (r_len == '0) begin
                    w_next = S_DONE;
                end else if (r_len > LEN_W'(MEM_BYTES)) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_fire && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (start_i) begin
                    w_next = S_HDR;
                end
            end
            default: w_next = S_HDR;
        endcase
    end

    always_comb begin
        w_ready_d   = 1'b0;
        w_cpu_rst_d = 1'b1;
        w_done_d    = 1'b0;
        w_err_d     = 1'b0;
        case (w_next)
            S_HDR, S_LOAD: w_ready_d = 1'b1;
            S_DONE: begin
                w_done_d    = 1'b1;
                w_cpu_rst_d = 1'b0;
            end
            S_ERR:   w_err_d = 1'b1;
            default: w_ready_d = 1'b0;
        endcase
    end

    // Status flags are registered from the next state so they line up with the last write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_cnt <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= ADDRESS_WIDTH'(BASE_ADDR);
            r_wdata   <= '0;
            r_sum     <= '0;
            r_ready   <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ready   <= w_ready_d;
            r_cpu_rst <= w_cpu_rst_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
            r_we      <= 1'b0;
            if (w_rearm) begin
                r_hdr_cnt <= '0;
                r_len     <= '0;
                r_cnt     <= '0;
                r_waddr   <= ADDRESS_WIDTH'(BASE_ADDR);
                r_wdata   <= '0;
                r_sum     <= '0;
            end else if (w_fire && (r_state == S_HDR)) begin
                r_len[{r_hdr_cnt, 3'b000} +: 8] <= 8'(s_data_i);
                r_hdr_cnt                       <= r_hdr_cnt + 2'd1;
            end else if (w_fire && (r_state == S_LOAD)) begin
                r_we    <= 1'b1;
                r_waddr <= ADDRESS_WIDTH'(BASE_ADDR) + r_cnt;
                r_wdata <= s_data_i;
                r_sum   <= r_sum + 8'(s_data_i);
                r_cnt   <= r_cnt + ADDRESS_WIDTH'(1);
            end
        end
    end

    assign s_ready_o  = r_ready;
    assign we_o       = r_we;
    assign waddr_o    = r_waddr;
    assign wdata_o    = r_wdata;
    assign cpu_rst_o  = r_cpu_rst;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign checksum_o = r_sum;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: behavioural image model checked every cycle, plus
// directed images with literal expectations.
module tb_instr_loader;
    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam int          MEM  = 4096;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        start_i   = 1'b0;
    logic        s_valid_i = 1'b0;
    logic [7:0]  s_data_i  = 8'h00;
    logic        s_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [7:0]  wdata_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  checksum_o;

    instr_loader #(
        .BASE_ADDR    (BASE),
        .MEM_BYTES    (MEM),
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .we_o      (we_o),
        .waddr_o   (waddr_o),
        .wdata_o   (wdata_o),
        .cpu_rst_o (cpu_rst_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .checksum_o(checksum_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Image model: phases of a load, tracked with plain counters
    localparam int PH_HDR = 0, PH_EVAL = 1, PH_LOAD = 2, PH_DONE = 3, PH_ERR = 4;
    int          m_ph;
    int          m_hc;
    longint      m_len;
    longint      m_k;
    logic        e_ready, e_we, e_cpu_rst, e_done, e_err;
    logic [31:0] e_addr;
    logic [7:0]  e_data, e_sum;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        bit hs;
        if (rst) begin
            m_ph = PH_HDR; m_hc = 0; m_len = 0; m_k = 0;
            e_ready = 1'b1; e_we = 1'b0; e_addr = BASE; e_data = 8'h00; e_sum = 8'h00;
            e_cpu_rst = 1'b1; e_done = 1'b0; e_err = 1'b0;
            chk_en = 1'b1;
        end else begin
            hs   = s_valid_i && e_ready;
            e_we = 1'b0;
            case (m_ph)
                PH_HDR: if (hs) begin
                    m_len = m_len + (64'(s_data_i) << (8 * m_hc));
                    m_hc++;
                    if (m_hc == 4) m_ph = PH_EVAL;
                end
                PH_EVAL: begin
                    if (m_len == 0) m_ph = PH_DONE;
                    else if (m_len > MEM) m_ph = PH_ERR;
                    else m_ph = PH_LOAD;
                end
                PH_LOAD: if (hs) begin
                    e_we   = 1'b1;
                    e_addr = BASE + 32'(m_k);
                    e_data = s_data_i;
                    e_sum  = e_sum + s_data_i;
                    m_k++;
                    if (m_k == m_len) m_ph = PH_DONE;
                end
                default: if (start_i) begin
                    m_ph = PH_HDR; m_hc = 0; m_len = 0; m_k = 0;
                    e_addr = BASE; e_data = 8'h00; e_sum = 8'h00;
                end
            endcase
            e_ready   = (m_ph == PH_HDR) || (m_ph == PH_LOAD);
            e_done    = (m_ph == PH_DONE);
            e_err     = (m_ph == PH_ERR);
            e_cpu_rst = !e_done;
        end
    end

    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready_o", 32'(s_ready_o), 32'(e_ready));
            chk("we_o", 32'(we_o), 32'(e_we));
            chk("waddr_o", waddr_o, e_addr);
            chk("wdata_o", 32'(wdata_o), 32'(e_data));
            chk("checksum_o", 32'(checksum_o), 32'(e_sum));
            chk("cpu_rst_o", 32'(cpu_rst_o), 32'(e_cpu_rst));
            chk("done_o", 32'(done_o), 32'(e_done));
            chk("err_o", 32'(err_o), 32'(e_err));
            if (we_o === 1'b1) begin
                wr_addr.push_back(waddr_o);
                wr_data.push_back(wdata_o);
            end
        end
    end

    // Called just after a negedge; holds the byte until a cycle with ready high
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = s_ready_o;
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        s_valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [31:0] len, input int gap);
        for (int i = 0; i < 4; i++) begin
            send(8'(len >> (8 * i)));
            idle(gap);
        end
    endtask

    task automatic rearm();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("rearm_ready", 32'(s_ready_o), 32'd1);
        chk("rearm_done", 32'(done_o), 32'd0);
        chk("rearm_err", 32'(err_o), 32'd0);
        chk("rearm_cpu_rst", 32'(cpu_rst_o), 32'd1);
    endtask

    logic [7:0] img1[4] = '{8'h13, 8'h05, 8'hA0, 8'h00};

    task automatic check_img1(input int base);
        chk("img1_count", 32'(wr_addr.size() - base), 32'd4);
        if (wr_addr.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("img1_addr", wr_addr[base + i], 32'hBFC00000 + 32'(i));
                chk("img1_data", 32'(wr_data[base + i]), 32'(img1[i]));
            end
        end
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(s_ready_o), 32'd1);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_waddr", waddr_o, 32'hBFC00000);
        chk("rst_wdata", 32'(wdata_o), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_sum", 32'(checksum_o), 32'd0);

        // Four-byte image, continuous valid
        base = wr_addr.size();
        send_hdr(32'd4, 0);
        for (int i = 0; i < 4; i++) send(img1[i]);
        chk("t1_last_we", 32'(we_o), 32'd1);
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_cpu_rst", 32'(cpu_rst_o), 32'd0);
        chk("t1_sum", 32'(checksum_o), 32'h0000_00B8);
        idle(2);
        check_img1(base);

        // Same image, valid toggling every other cycle
        rearm();
        base = wr_addr.size();
        send_hdr(32'd4, 1);
        for (int i = 0; i < 4; i++) begin
            send(img1[i]);
            if (i < 3) idle(1);
        end
        chk("t2_done", 32'(done_o), 32'd1);
        chk("t2_sum", 32'(checksum_o), 32'h0000_00B8);
        idle(2);
        check_img1(base);

        // Zero-length image
        rearm();
        base = wr_addr.size();
        send_hdr(32'd0, 0);
        chk("t3_eval_ready", 32'(s_ready_o), 32'd0);
        chk("t3_eval_done", 32'(done_o), 32'd0);
        idle(1);
        chk("t3_done", 32'(done_o), 32'd1);
        chk("t3_cpu_rst", 32'(cpu_rst_o), 32'd0);
        chk("t3_ready", 32'(s_ready_o), 32'd0);
        chk("t3_writes", 32'(wr_addr.size() - base), 32'd0);

        // Oversized header (4097)
        rearm();
        base = wr_addr.size();
        send_hdr(32'h0000_1001, 0);
        idle(1);
        chk("t4_err", 32'(err_o), 32'd1);
        chk("t4_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("t4_ready", 32'(s_ready_o), 32'd0);
        s_valid_i = 1'b1;
        s_data_i  = 8'h55;
        repeat (2) @(negedge clk);
        s_valid_i = 1'b0;
        chk("t4_writes", 32'(wr_addr.size() - base), 32'd0);
        rearm();

        // Full-capacity image
        base = wr_addr.size();
        send_hdr(32'd4096, 0);
        for (int i = 0; i < 4096; i++) send(8'(i));
        chk("t5_we", 32'(we_o), 32'd1);
        chk("t5_waddr", waddr_o, 32'hBFC00FFF);
        chk("t5_wdata", 32'(wdata_o), 32'h0000_00FF);
        chk("t5_done", 32'(done_o), 32'd1);
        chk("t5_sum", 32'(checksum_o), 32'd0);
        s_valid_i = 1'b1;
        s_data_i  = 8'h77;
        repeat (3) @(negedge clk);
        chk("t5_extra_ready", 32'(s_ready_o), 32'd0);
        s_valid_i = 1'b0;
        idle(1);
        chk("t5_count", 32'(wr_addr.size() - base), 32'd4096);
        chk("t5_last_addr", wr_addr[wr_addr.size() - 1], 32'hBFC00FFF);

        // Reset mid-load (start_i during LOAD ignored; rst beats start_i), then fresh image
        rearm();
        send_hdr(32'd4, 0);
        start_i = 1'b1;
        send(8'h11);
        start_i = 1'b0;
        send(8'h22);
        rst     = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        chk("t6_rst_ready", 32'(s_ready_o), 32'd1);
        chk("t6_rst_waddr", waddr_o, 32'hBFC00000);
        chk("t6_rst_sum", 32'(checksum_o), 32'd0);
        chk("t6_rst_done", 32'(done_o), 32'd0);
        base = wr_addr.size();
        send_hdr(32'd2, 0);
        send(8'hAA);
        send(8'hBB);
        chk("t6_done", 32'(done_o), 32'd1);
        chk("t6_sum", 32'(checksum_o), 32'h0000_0065);
        idle(2);
        chk("t6_count", 32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() >= base + 2) begin
            chk("t6_addr0", wr_addr[base], 32'hBFC00000);
            chk("t6_data0", 32'(wr_data[base]), 32'h0000_00AA);
            chk("t6_addr1", wr_addr[base + 1], 32'hBFC00001);
            chk("t6_data1", 32'(wr_data[base + 1]), 32'h0000_00BB);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer-side counterpart to the byte-addressable instruction memory: accepts a byte stream (length header + payload) and produces byte write strobes into instruction memory, starting at the boot base address.
- Holds the core in reset while loading; releases it when the image is complete.
- Sits between the host/UART byte source and the instruction-memory write port.

Parameters:
- BASE_ADDR, 32'hBFC00000, absolute address of payload byte 0.
- MEM_BYTES, 4096, instruction memory capacity in bytes.
- ADDRESS_WIDTH, 32, width of the write address.
- DATA_WIDTH, 8, width of one stream byte / write datum.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  re-arm pulse; honoured only in DONE or ERR
- s_valid_i  input  1  stream byte valid
- s_data_i  input  DATA_WIDTH  stream byte
- s_ready_o  output  1  loader can accept a byte
- we_o  output  1  instruction-memory byte write enable
- waddr_o  output  ADDRESS_WIDTH  absolute byte write address
- wdata_o  output  DATA_WIDTH  byte to write
- cpu_rst_o  output  1  core reset request, high until load completes
- done_o  output  1  image loaded successfully
- err_o  output  1  header length exceeded MEM_BYTES
- checksum_o  output  8  mod-256 sum of payload bytes written

Behaviour:
- Transfer occurs when s_valid_i && s_ready_o on a rising edge; s_data_i may change freely otherwise.
- States:
  - HDR: collect 4 header bytes, little-endian. The first byte is len[7:0].
  - LOAD: write payload.
  - DONE.
  - ERR.
- Reset (any time, including mid-load):
  - state=HDR, header byte count=0, len=0, byte count=0.
  - we_o=0, waddr_o=BASE_ADDR, wdata_o=0, checksum_o=0.
  - cpu_rst_o=1, done_o=0, err_o=0.
  - s_ready_o=1 from the first cycle after reset.
- s_ready_o=1 in HDR and LOAD, 0 in DONE and ERR.
- HDR:
  - On the 4th accepted byte, the assembled length is evaluated in the following cycle.
  - len==0: go to DONE.
  - len>MEM_BYTES: go to ERR.
  - Otherwise: go to LOAD.
  - s_ready_o is 0 during that single evaluation cycle.
- LOAD, per accepted byte k (0-based):
  - Next cycle: we_o=1, waddr_o=BASE_ADDR+k, wdata_o=byte, checksum_o += byte (wraps mod 256).
  - Write latency is exactly 1 cycle after the handshake.
  - we_o=0 in any cycle with no preceding handshake.
  - Back-to-back handshakes produce back-to-back writes.
- LOAD exit: after accepting byte len-1, go to DONE.
  - The final write (we_o=1) is issued in the same cycle that done_o rises.
  - cpu_rst_o falls in that cycle.
  - Byte count is ADDRESS_WIDTH wide; len==MEM_BYTES is legal, last address BASE_ADDR+MEM_BYTES-1.
- DONE:
  - done_o=1, cpu_rst_o=0, s_ready_o=0.
  - Extra stream bytes are ignored and never written.
  - waddr_o and checksum_o hold their last values.
- ERR:
  - err_o=1, cpu_rst_o stays 1, s_ready_o=0, no writes issued.
- start_i in DONE or ERR:
  - Returns to HDR next cycle with counters and checksum cleared, done_o/err_o=0, cpu_rst_o=1.
  - start_i in HDR or LOAD is ignored.
- rst and start_i asserted together: rst wins.
- Source stalls (s_valid_i=0) in any state: no state change and no write.

Test Plan:
- Header 04 00 00 00, payload 13 05 A0 00 streamed with continuous valid:
  - 4 writes: BFC00000=13, BFC00001=05, BFC00002=A0, BFC00003=00.
  - done_o=1 and cpu_rst_o=0 in the cycle of the last write.
  - checksum_o=0xB8.
- Same image with s_valid_i toggling every other cycle -> identical writes and addresses; no write in stall cycles.
- Header 00 00 00 00 -> no writes; DONE after the evaluation cycle; cpu_rst_o=0; s_ready_o=0.
- Header 01 10 00 00 (len=4097) -> err_o=1, cpu_rst_o=1, no writes. start_i -> back to HDR with s_ready_o=1.
- len=4096 with byte i = i[7:0] -> last write BFC00FFF=FF, done_o=1. A further valid byte is not accepted.
- rst asserted after the 2nd payload byte, then a fresh 2-byte image AA BB -> writes restart at BFC00000=AA, BFC00001=BB; checksum_o=0x65.
